// File: rtl/bitrev_frame_arb.sv
// bitrev_frame_arb: round-robin arbiter that shares one bitrev core between NR
// stream requesters. It grants one whole frame at a time and remembers the owner
// of each granted frame, so the reordered frame can be steered back to that owner.
module bitrev_frame_arb #(
  parameter int K         = 10,
  parameter int DW        = 32,
  parameter int NR        = 4,
  parameter int OWN_DEPTH = 2
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic [NR-1:0]                    req_valid_i,
  input  logic [NR*DW-1:0]                 req_data_i,
  output logic [NR-1:0]                    req_ready_o,
  output logic [NR-1:0]                    rsp_valid_o,
  output logic [DW-1:0]                    rsp_data_o,
  input  logic [NR-1:0]                    rsp_ready_i,
  output logic                             core_valid_o,
  output logic [DW-1:0]                    core_data_o,
  input  logic                             core_ready_i,
  input  logic                             core_valid_i,
  input  logic [DW-1:0]                    core_data_i,
  output logic                             core_ready_o,
  output logic [$clog2(OWN_DEPTH+1)-1:0]   inflight_o,
  output logic                             busy_o
);

  localparam int GW = (NR > 1) ? $clog2(NR) : 1;
  localparam int PW = (OWN_DEPTH > 1) ? $clog2(OWN_DEPTH) : 1;
  localparam int CW = $clog2(OWN_DEPTH + 1);
  localparam logic [K-1:0] LAST = '1;

  typedef enum logic {IDLE, FRAME} state_e;

  state_e          state_q, state_d;
  logic [GW-1:0]   grant_q, grant_d;
  logic [GW-1:0]   rr_q, rr_d;
  logic [K-1:0]    in_cnt_q, in_cnt_d;
  logic [K-1:0]    out_cnt_q, out_cnt_d;
  logic [GW-1:0]   own_mem_q [OWN_DEPTH];
  logic [PW-1:0]   wr_q, wr_d;
  logic [PW-1:0]   rd_q, rd_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic            pick_found;
  logic [GW-1:0]   pick_idx;
  logic            push;
  logic            pop;
  logic            in_beat;
  logic            out_beat;
  logic            fifo_empty;
  logic            fifo_full;
  logic [GW-1:0]   head;

  assign fifo_empty = (cnt_q == '0);
  assign fifo_full  = (cnt_q == CW'(OWN_DEPTH));
  assign head       = own_mem_q[rd_q];
  assign inflight_o = cnt_q;
  assign busy_o     = (state_q == FRAME) || !fifo_empty;

  // Round-robin search: first valid requester after rr_q, wrapping around.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int i = 1; i <= NR; i++) begin
      if (!pick_found && req_valid_i[GW'((int'(rr_q) + i) % NR)]) begin
        pick_found = 1'b1;
        pick_idx   = GW'((int'(rr_q) + i) % NR);
      end
    end
  end

  // Output side: steer core output to the owner at the FIFO head, count beats.
  always_comb begin
    rsp_valid_o  = '0;
    rsp_data_o   = '0;
    core_ready_o = 1'b0;
    if (!fifo_empty) begin
      rsp_valid_o[head] = core_valid_i;
      core_ready_o      = rsp_ready_i[head];
      rsp_data_o        = core_data_i;
    end
    out_beat  = !fifo_empty && core_valid_i && rsp_ready_i[head];
    pop       = out_beat && (out_cnt_q == LAST);
    out_cnt_d = out_beat ? out_cnt_q + 1'b1 : out_cnt_q;
  end

  // Input FSM next-state: grant in IDLE (a pop in the same cycle frees a slot),
  // then pass exactly N beats from the granted requester to the core.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    rr_d         = rr_q;
    in_cnt_d     = in_cnt_q;
    push         = 1'b0;
    in_beat      = 1'b0;
    core_valid_o = 1'b0;
    core_data_o  = '0;
    req_ready_o  = '0;
    case (state_q)
      IDLE: begin
        if (pick_found && (!fifo_full || pop)) begin
          grant_d = pick_idx;
          push    = 1'b1;
          state_d = FRAME;
        end
      end
      FRAME: begin
        core_valid_o         = req_valid_i[grant_q];
        core_data_o          = req_data_i[int'(grant_q)*DW +: DW];
        req_ready_o[grant_q] = core_ready_i;
        in_beat              = req_valid_i[grant_q] && core_ready_i;
        if (in_beat) begin
          in_cnt_d = in_cnt_q + 1'b1;
          if (in_cnt_q == LAST) begin
            rr_d    = grant_q;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Owner FIFO pointer and occupancy update; push and pop may coincide.
  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (push) wr_d = (wr_q == PW'(OWN_DEPTH - 1)) ? '0 : wr_q + 1'b1;
    if (pop)  rd_d = (rd_q == PW'(OWN_DEPTH - 1)) ? '0 : rd_q + 1'b1;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // State registers; reset discards any partial frame and all recorded owners.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      rr_q      <= GW'(NR - 1);
      in_cnt_q  <= '0;
      out_cnt_q <= '0;
      wr_q      <= '0;
      rd_q      <= '0;
      cnt_q     <= '0;
      for (int i = 0; i < OWN_DEPTH; i++) own_mem_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      rr_q      <= rr_d;
      in_cnt_q  <= in_cnt_d;
      out_cnt_q <= out_cnt_d;
      wr_q      <= wr_d;
      rd_q      <= rd_d;
      cnt_q     <= cnt_d;
      if (push) own_mem_q[wr_q] <= grant_d;
    end
  end

endmodule

// File: tb/tb_bitrev_frame_arb.sv
// Bench for bitrev_frame_arb with a behavioural two-frame bitrev core model.
module tb_bitrev_frame_arb;
  localparam int K = 3;
  localparam int DW = 32;
  localparam int NR = 4;
  localparam int OWN_DEPTH = 2;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic [3:0]    req_valid_i = '0;
  logic [127:0]  req_data_i = '0;
  logic [3:0]    req_ready_o;
  logic [3:0]    rsp_valid_o;
  logic [31:0]   rsp_data_o;
  logic [3:0]    rsp_ready_i = '0;
  logic          core_valid_o;
  logic [31:0]   core_data_o;
  logic          core_ready_i;
  logic          core_valid_i;
  logic [31:0]   core_data_i;
  logic          core_ready_o;
  logic [1:0]    inflight_o;
  logic          busy_o;

  bitrev_frame_arb #(.K(K), .DW(DW), .NR(NR), .OWN_DEPTH(OWN_DEPTH)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_data_i(req_data_i), .req_ready_o(req_ready_o),
    .rsp_valid_o(rsp_valid_o), .rsp_data_o(rsp_data_o), .rsp_ready_i(rsp_ready_i),
    .core_valid_o(core_valid_o), .core_data_o(core_data_o), .core_ready_i(core_ready_i),
    .core_valid_i(core_valid_i), .core_data_i(core_data_i), .core_ready_o(core_ready_o),
    .inflight_o(inflight_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [2:0] brev3(input logic [2:0] x);
    return {x[0], x[1], x[2]};
  endfunction

  function automatic logic [31:0] mk(input int r, input int seq, input int beat);
    return {8'(r), 16'(seq), 8'(beat)};
  endfunction

  // bitrev core model: two frame buffers, output reads bit-reversed addresses
  logic [31:0] cmem [2][8];
  logic [1:0]  ccnt;
  logic        wslot, rslot;
  logic [2:0]  cin, cout;
  wire         c_in_beat  = core_valid_o && core_ready_i;
  wire         c_out_beat = core_valid_i && core_ready_o;
  assign core_ready_i = (ccnt < 2'd2);
  assign core_valid_i = (ccnt != 2'd0);
  assign core_data_i  = cmem[rslot][brev3(cout)];

  always @(posedge clk_i) begin
    if (rst_i) begin
      ccnt <= '0; wslot <= 1'b0; rslot <= 1'b0; cin <= '0; cout <= '0;
    end else begin
      if (c_in_beat) begin
        cmem[wslot][cin] <= core_data_o;
        cin <= cin + 3'd1;
        if (cin == 3'd7) wslot <= ~wslot;
      end
      if (c_out_beat) begin
        cout <= cout + 3'd1;
        if (cout == 3'd7) rslot <= ~rslot;
      end
      ccnt <= ccnt + 2'(c_in_beat && cin == 3'd7) - 2'(c_out_beat && cout == 3'd7);
    end
  end

  // bench state
  int          vectors = 0;
  int          miscompares = 0;
  int          cycle = 0;
  int          gap_pct = 0;
  bit          rsp_rand = 1'b0;
  logic [3:0]  rsp_fix = 4'hF;
  logic [31:0] send_q [4][$];
  logic [31:0] coll [4][$];
  logic [31:0] exp_q [4][$];
  int          grant_log[$];
  int          rx_port[$];
  logic [31:0] rx_data[$];
  int          rx_cnt [4];
  int          first_acc [4];
  int          first_pop = -1;
  logic [31:0] mon_exp;

  task automatic clear_bench();
    for (int r = 0; r < 4; r++) begin
      send_q[r].delete(); coll[r].delete(); exp_q[r].delete();
      rx_cnt[r] = 0; first_acc[r] = -1;
    end
    grant_log.delete(); rx_port.delete(); rx_data.delete();
    first_pop = -1;
  endtask

  // one cycle: drive requester inputs, then log accepted beats into the scoreboard
  task automatic step();
    @(negedge clk_i);
    cycle++;
    for (int r = 0; r < 4; r++) begin
      if (send_q[r].size() > 0 && !(gap_pct > 0 && int'($urandom_range(99)) < gap_pct)) begin
        req_valid_i[r] = 1'b1;
        req_data_i[r*32 +: 32] = send_q[r][0];
      end else begin
        req_valid_i[r] = 1'b0;
        req_data_i[r*32 +: 32] = '0;
      end
    end
    rsp_ready_i = rsp_rand ? 4'($urandom_range(15)) : rsp_fix;
    #1;
    for (int r = 0; r < 4; r++) begin
      if (!rst_i && req_valid_i[r] && req_ready_o[r]) begin
        if (coll[r].size() == 0) grant_log.push_back(r);
        if (first_acc[r] < 0) first_acc[r] = cycle;
        coll[r].push_back(send_q[r].pop_front());
        if (coll[r].size() == 8) begin
          for (int j = 0; j < 8; j++) exp_q[r].push_back(coll[r][brev3(3'(j))]);
          coll[r].delete();
        end
      end
    end
  endtask

  task automatic apply_reset();
    rst_i = 1'b1;
    clear_bench();
    step(); step();
    rst_i = 1'b0;
  endtask

  task automatic drain(input int budget, output bit ok);
    bit done;
    ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      step();
      done = (busy_o == 1'b0);
      for (int r = 0; r < 4; r++)
        if (send_q[r].size() != 0 || exp_q[r].size() != 0 || coll[r].size() != 0) done = 1'b0;
      if (done) begin ok = 1'b1; break; end
    end
  endtask

  // response scoreboard: pop the owner's expected word on every output beat
  always begin
    @(negedge clk_i);
    #2;
    if (!rst_i) begin
      vectors++;
      if (!$onehot0(rsp_valid_o)) begin
        miscompares++;
        $display("FAIL rsp_onehot got %b expected at most one bit", rsp_valid_o);
      end
      for (int r = 0; r < 4; r++) begin
        if (rsp_valid_o[r] && rsp_ready_i[r]) begin
          vectors++;
          if (exp_q[r].size() == 0) begin
            miscompares++;
            $display("FAIL rsp_unexpected port %0d got %h expected no beat", r, rsp_data_o);
          end else begin
            mon_exp = exp_q[r].pop_front();
            if (rsp_data_o !== mon_exp) begin
              miscompares++;
              $display("FAIL rsp_data port %0d got %h expected %h", r, rsp_data_o, mon_exp);
            end
          end
          rx_port.push_back(r);
          rx_data.push_back(rsp_data_o);
          rx_cnt[r]++;
          if (rx_cnt[r] % 8 == 0 && first_pop < 0) first_pop = cycle;
        end
      end
    end
  end

  task automatic test_reset();
    rst_i = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk_i);
      req_valid_i = 4'hF;
      #1;
      vectors++;
      if ({req_ready_o, rsp_valid_o, rsp_data_o, core_valid_o, core_data_o, core_ready_o,
           inflight_o, busy_o} !== '0) begin
        miscompares++;
        $display("FAIL reset_outputs rdy=%b rv=%b rd=%h cv=%b cd=%h cr=%b inf=%0d busy=%b expected all 0",
                 req_ready_o, rsp_valid_o, rsp_data_o, core_valid_o, core_data_o, core_ready_o,
                 inflight_o, busy_o);
      end
    end
    req_valid_i = '0;
    rst_i = 1'b0;
    clear_bench();
    step();
    vectors++;
    if ({req_ready_o, rsp_valid_o, core_valid_o, core_ready_o, inflight_o, busy_o} !== '0) begin
      miscompares++;
      $display("FAIL post_reset_idle rdy=%b rv=%b cv=%b inf=%0d busy=%b expected all 0",
               req_ready_o, rsp_valid_o, core_valid_o, inflight_o, busy_o);
    end
  endtask

  task automatic test_single();
    bit ok;
    logic [31:0] want [8];
    want = '{32'd0, 32'd4, 32'd2, 32'd6, 32'd1, 32'd5, 32'd3, 32'd7};
    apply_reset();
    for (int b = 0; b < 8; b++) send_q[0].push_back(32'(b));
    for (int c = 0; c < 20 && first_acc[0] < 0; c++) step();
    vectors++;
    if (inflight_o !== 2'd1) begin
      miscompares++;
      $display("FAIL single_inflight got %0d expected 1", inflight_o);
    end
    drain(200, ok);
    vectors++;
    if (!ok || inflight_o !== 2'd0) begin
      miscompares++;
      $display("FAIL single_drain ok=%0b inflight got %0d expected drained with 0", ok, inflight_o);
    end
    vectors++;
    if (rx_data.size() != 8) begin
      miscompares++;
      $display("FAIL single_count got %0d expected 8", rx_data.size());
    end else begin
      for (int j = 0; j < 8; j++) begin
        vectors++;
        if (rx_data[j] !== want[j] || rx_port[j] != 0) begin
          miscompares++;
          $display("FAIL single_order idx %0d got port %0d data %0d expected port 0 data %0d",
                   j, rx_port[j], rx_data[j], want[j]);
        end
      end
    end
  endtask

  task automatic test_contention();
    bit ok;
    apply_reset();
    for (int b = 0; b < 8; b++) begin
      send_q[0].push_back(mk(0, 1, b));
      send_q[2].push_back(mk(2, 1, b));
    end
    drain(300, ok);
    vectors++;
    if (!ok || grant_log.size() != 2) begin
      miscompares++;
      $display("FAIL contention_drain ok=%0b grants got %0d expected 2", ok, grant_log.size());
    end else begin
      vectors++;
      if (grant_log[0] != 0 || grant_log[1] != 2) begin
        miscompares++;
        $display("FAIL contention_order got %0d,%0d expected 0,2", grant_log[0], grant_log[1]);
      end
    end
    vectors++;
    if (rx_port.size() != 16 || rx_port[0] != 0 || rx_port[15] != 2) begin
      miscompares++;
      $display("FAIL contention_ports got n=%0d expected 16 beats, port 0 first and port 2 last",
               rx_port.size());
    end
  endtask

  task automatic test_fairness();
    bit ok;
    int want [8];
    want = '{0, 1, 2, 3, 0, 1, 2, 3};
    apply_reset();
    for (int r = 0; r < 4; r++)
      for (int f = 0; f < 2; f++)
        for (int b = 0; b < 8; b++) send_q[r].push_back(mk(r, f, b));
    drain(1000, ok);
    vectors++;
    if (!ok || grant_log.size() != 8) begin
      miscompares++;
      $display("FAIL fairness_drain ok=%0b grants got %0d expected 8", ok, grant_log.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        vectors++;
        if (grant_log[i] != want[i]) begin
          miscompares++;
          $display("FAIL fairness_grant idx %0d got %0d expected %0d", i, grant_log[i], want[i]);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    apply_reset();
    rsp_fix = 4'h0;
    for (int r = 0; r < 3; r++)
      for (int b = 0; b < 8; b++) send_q[r].push_back(mk(r, 7, b));
    repeat (60) step();
    vectors++;
    if (inflight_o !== 2'd2 || busy_o !== 1'b1) begin
      miscompares++;
      $display("FAIL bp_inflight got %0d busy %b expected 2 busy 1", inflight_o, busy_o);
    end
    vectors++;
    if (first_acc[2] != -1 || grant_log.size() != 2 || req_ready_o[2] !== 1'b0) begin
      miscompares++;
      $display("FAIL bp_third_blocked got grants %0d acc2 %0d expected 2 grants and no req2 beat",
               grant_log.size(), first_acc[2]);
    end
    rsp_fix = 4'hF;
    drain(400, ok);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL bp_drain got not drained expected drained");
    end
    vectors++;
    if (first_pop < 0 || first_acc[2] != first_pop + 1) begin
      miscompares++;
      $display("FAIL bp_grant_after_pop got req2 first beat cycle %0d expected %0d",
               first_acc[2], first_pop + 1);
    end
  endtask

  task automatic test_stall_reset();
    bit ok;
    apply_reset();
    gap_pct  = 30;
    rsp_rand = 1'b1;
    for (int r = 0; r < 4; r++)
      for (int f = 0; f < 2; f++)
        for (int b = 0; b < 8; b++) send_q[r].push_back(mk(r, 10 + f, b));
    drain(3000, ok);
    vectors++;
    if (!ok || rx_data.size() != 64) begin
      miscompares++;
      $display("FAIL stall_count ok=%0b got %0d beats expected 64", ok, rx_data.size());
    end
    gap_pct  = 0;
    rsp_rand = 1'b0;
    rsp_fix  = 4'hF;
    for (int b = 0; b < 8; b++) send_q[1].push_back(mk(1, 20, b));
    for (int c = 0; c < 100 && coll[1].size() < 5; c++) step();
    vectors++;
    if (coll[1].size() != 5) begin
      miscompares++;
      $display("FAIL midreset_reach got %0d beats expected 5", coll[1].size());
    end
    rst_i = 1'b1;
    clear_bench();
    step();
    rst_i = 1'b0;
    step();
    vectors++;
    if (inflight_o !== 2'd0 || busy_o !== 1'b0 || core_valid_o !== 1'b0 || rsp_valid_o !== 4'h0) begin
      miscompares++;
      $display("FAIL midreset_clear inf=%0d busy=%b cv=%b rv=%b expected all 0",
               inflight_o, busy_o, core_valid_o, rsp_valid_o);
    end
    for (int b = 0; b < 8; b++) send_q[3].push_back(mk(3, 30, b));
    drain(300, ok);
    vectors++;
    if (!ok || rx_data.size() != 8 || grant_log.size() != 1) begin
      miscompares++;
      $display("FAIL midreset_next ok=%0b beats %0d grants %0d expected drained, 8 beats, 1 grant",
               ok, rx_data.size(), grant_log.size());
    end
  endtask

  initial begin
    clear_bench();
    test_reset();
    test_single();
    test_contention();
    test_fairness();
    test_backpressure();
    test_stall_reset();
    repeat (2) @(negedge clk_i);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
